// File: rtl/i2s_pkg.sv
// Shared I2S definitions: slot geometry and receiver FSM states.
`timescale 1ns/1ps
package i2s_pkg;

  localparam int unsigned I2S_SLOT_BITS = 32;
  localparam int unsigned I2S_CNT_W     = $clog2(I2S_SLOT_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_sync.sv
// Synchronizes sclk/lrck/sdin into clk and flags sclk rising edges.
// All three paths have equal depth so the sampled lrck/sdin line up with the strobe.
`timescale 1ns/1ps
module i2s_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_i,
  input  logic lrck_i,
  input  logic sdin_i,
  output logic sclk_rise_o,
  output logic lrck_o,
  output logic sdin_o
);

  logic [STAGES-1:0] sclk_q;
  logic [STAGES-1:0] lrck_q;
  logic [STAGES-1:0] sdin_q;
  logic              sclk_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q      <= '0;
      lrck_q      <= '0;
      sdin_q      <= '0;
      sclk_d_q    <= 1'b0;
      sclk_rise_o <= 1'b0;
      lrck_o      <= 1'b0;
      sdin_o      <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[STAGES-2:0], sclk_i};
      lrck_q      <= {lrck_q[STAGES-2:0], lrck_i};
      sdin_q      <= {sdin_q[STAGES-2:0], sdin_i};
      sclk_d_q    <= sclk_q[STAGES-1];
      sclk_rise_o <= sclk_q[STAGES-1] & ~sclk_d_q;
      lrck_o      <= lrck_q[STAGES-1];
      sdin_o      <= sdin_q[STAGES-1];
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: deserializes MSB-first left/right words and emits coherent pairs.
`timescale 1ns/1ps
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              lrck,
  input  logic              sdin,
  output logic [DATA_W-1:0] l_data,
  output logic [DATA_W-1:0] r_data,
  output logic              valid,
  output logic              err
);

  localparam logic [I2S_CNT_W-1:0] LAST_BIT  = I2S_CNT_W'(DATA_W - 1);
  localparam bit                   FULL_SLOT = (DATA_W == I2S_SLOT_BITS);

  logic rise_stb, lrck_s, sdin_s;

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk_i     (sclk),
    .lrck_i     (lrck),
    .sdin_i     (sdin),
    .sclk_rise_o(rise_stb),
    .lrck_o     (lrck_s),
    .sdin_o     (sdin_s)
  );

  i2s_rx_state_t        state_q, state_d;
  logic [I2S_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 chan_q, chan_d;
  logic [DATA_W-1:0]    shreg_q, shreg_d;
  logic [DATA_W-1:0]    left_q, left_d;
  logic                 left_vld_q, left_vld_d;
  logic                 lrck_prev_q, lrck_prev_d;
  logic                 primed_q, primed_d;
  logic [DATA_W-1:0]    l_data_q, l_data_d;
  logic [DATA_W-1:0]    r_data_q, r_data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic [DATA_W-1:0]    shift_in;
  logic                 boundary, word_done, start_slot;

  // The first strobe after reset only learns lrck, so a reset released
  // mid-slot never looks like a slot boundary.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    chan_d      = chan_q;
    shreg_d     = shreg_q;
    left_d      = left_q;
    left_vld_d  = left_vld_q;
    lrck_prev_d = lrck_prev_q;
    primed_d    = primed_q;
    l_data_d    = l_data_q;
    r_data_d    = r_data_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    word_done   = 1'b0;
    start_slot  = 1'b0;
    shift_in    = {shreg_q[DATA_W-2:0], sdin_s};
    boundary    = primed_q && (lrck_s != lrck_prev_q);

    if (rise_stb) begin
      lrck_prev_d = lrck_s;
      primed_d    = 1'b1;
      unique case (state_q)
        IDLE: start_slot = boundary;
        SHIFT: begin
          if (boundary) begin
            // A full 32-bit word takes its LSB on the boundary strobe.
            if (FULL_SLOT && (bit_cnt_q == LAST_BIT)) begin
              word_done = 1'b1;
            end else begin
              err_d      = 1'b1;
              left_vld_d = 1'b0;
            end
            start_slot = 1'b1;
          end else begin
            shreg_d = shift_in;
            if (bit_cnt_q == LAST_BIT) begin
              word_done = 1'b1;
              state_d   = PAD;
            end else begin
              bit_cnt_d = bit_cnt_q + I2S_CNT_W'(1);
            end
          end
        end
        PAD:     start_slot = boundary;
        default: state_d = IDLE;
      endcase

      if (word_done) begin
        if (!chan_q) begin
          left_d     = shift_in;
          left_vld_d = 1'b1;
        end else begin
          if (left_vld_q) begin
            l_data_d = left_q;
            r_data_d = shift_in;
            valid_d  = 1'b1;
          end
          left_vld_d = 1'b0;
        end
      end

      if (start_slot) begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
        chan_d    = lrck_s;
        if (!lrck_s) left_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      chan_q      <= 1'b0;
      shreg_q     <= '0;
      left_q      <= '0;
      left_vld_q  <= 1'b0;
      lrck_prev_q <= 1'b0;
      primed_q    <= 1'b0;
      l_data_q    <= '0;
      r_data_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      chan_q      <= chan_d;
      shreg_q     <= shreg_d;
      left_q      <= left_d;
      left_vld_q  <= left_vld_d;
      lrck_prev_q <= lrck_prev_d;
      primed_q    <= primed_d;
      l_data_q    <= l_data_d;
      r_data_q    <= r_data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign l_data = l_data_q;
  assign r_data = r_data_q;
  assign valid  = valid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: 24-bit and 16-bit receivers share one I2S bus.
`timescale 1ns/1ps
module tb_i2s_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic lrck = 1'b0;
  logic sdin = 1'b0;
  logic [23:0] l24, r24;
  logic [15:0] l16, r16;
  logic v24, e24, v16, e16;

  always #22 clk = ~clk;

  i2s_rx #(.DATA_W(24), .SYNC_STAGES(2)) dut24 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .lrck(lrck), .sdin(sdin),
    .l_data(l24), .r_data(r24), .valid(v24), .err(e24)
  );

  i2s_rx #(.DATA_W(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .lrck(lrck), .sdin(sdin),
    .l_data(l16), .r_data(r16), .valid(v16), .err(e16)
  );

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
  } pair_t;

  pair_t q24[$];
  pair_t q16[$];
  int tests = 0;
  int fails = 0;
  int errs24 = 0;
  int errs16 = 0;
  logic carry = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One sclk period: data/lrck change with the falling edge, 4 clk low, 4 clk high.
  task automatic send_bit(input logic lr, input logic b);
    sclk = 1'b0;
    lrck = lr;
    sdin = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // First bit of a slot carries the previous slot's LSB (I2S one-bit delay).
  task automatic send_slot(input logic lr, input logic [31:0] w, input int nbits, input int stall_at);
    send_bit(lr, carry);
    for (int i = 1; i < nbits; i++) begin
      send_bit(lr, w[32-i]);
      if (i == stall_at) repeat (1000) @(negedge clk);
    end
    carry = w[32-nbits];
  endtask

  task automatic frame(input logic [31:0] l, input logic [31:0] r);
    q24.push_back('{l, r});
    q16.push_back('{l, r});
    send_slot(1'b0, l, 32, -1);
    send_slot(1'b1, r, 32, -1);
    check("pending24", 32'(q24.size()), 32'd0);
    check("pending16", 32'(q16.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_l24"}, 32'(l24), 32'd0);
    check({tag, "_r24"}, 32'(r24), 32'd0);
    check({tag, "_v24"}, 32'(v24), 32'd0);
    check({tag, "_e24"}, 32'(e24), 32'd0);
    check({tag, "_l16"}, 32'(l16), 32'd0);
    check({tag, "_r16"}, 32'(r16), 32'd0);
    check({tag, "_v16"}, 32'(v16), 32'd0);
    check({tag, "_e16"}, 32'(e16), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every valid pulse, tallies err pulses.
  always @(negedge clk) begin
    pair_t p;
    if (e24) errs24++;
    if (e16) errs16++;
    if (v24) begin
      check("valid24_vs_err", 32'(e24), 32'd0);
      if (q24.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid24: got l=%h r=%h expected no valid", l24, r24);
      end else begin
        p = q24.pop_front();
        check("l_data24", 32'(l24), 32'(p.l[31:8]));
        check("r_data24", 32'(r24), 32'(p.r[31:8]));
      end
    end
    if (v16) begin
      check("valid16_vs_err", 32'(e16), 32'd0);
      if (q16.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid16: got l=%h r=%h expected no valid", l16, r16);
      end else begin
        p = q16.pop_front();
        check("l_data16", 32'(l16), 32'(p.l[31:16]));
        check("r_data16", 32'(r16), 32'(p.r[31:16]));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish expected finish before 5 ms");
    $fatal(1, "timeout");
  end

  logic [31:0] lt [8];
  logic [31:0] rt [8];

  initial begin
    lt = '{32'hA5A5A500, 32'hA5A5A5FF, 32'hA5A5A512, 32'hA5A5A5C3,
           32'hA5A5A501, 32'hA5A5A580, 32'hA5A5A57E, 32'hA5A5A5AA};
    rt = '{32'h5A5A5A00, 32'h5A5A5AFF, 32'h5A5A5A34, 32'h5A5A5A3C,
           32'h5A5A5A01, 32'h5A5A5A80, 32'h5A5A5A81, 32'h5A5A5A55};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Reset released in the middle of a right slot: that partial word is dropped.
    send_slot(1'b1, 32'h1234_5678, 8, -1);
    rst_n = 1'b1;
    send_slot(1'b1, 32'h9ABC_DEF0, 12, -1);

    for (int f = 0; f < 8; f++) frame(lt[f], rt[f]);
    frame(32'h8001_FFFF, 32'h7FFE_0001);
    frame(32'h0000_0000, 32'hFFFF_FFFF);
    check("err_clean24", 32'(errs24), 32'd0);
    check("err_clean16", 32'(errs16), 32'd0);

    // Left slot cut after 10 bits: err once, the following right word is dropped.
    send_slot(1'b0, 32'hFFFF_0000, 10, -1);
    send_slot(1'b1, 32'h1357_9BDF, 32, -1);
    check("trunc_err24", 32'(errs24), 32'd1);
    check("trunc_err16", 32'(errs16), 32'd1);
    check("trunc_nopair24", 32'(q24.size()), 32'd0);
    frame(32'hC0FF_EE11, 32'h0BAD_F00D);

    // sclk frozen for 1000 clk in the middle of a left slot.
    q24.push_back('{32'h1234_5678, 32'h8765_4321});
    q16.push_back('{32'h1234_5678, 32'h8765_4321});
    send_slot(1'b0, 32'h1234_5678, 32, 12);
    send_slot(1'b1, 32'h8765_4321, 32, -1);
    check("stall_pending24", 32'(q24.size()), 32'd0);
    check("stall_pending16", 32'(q16.size()), 32'd0);
    check("stall_err24", 32'(errs24), 32'd1);

    // Async reset during a left SHIFT, released mid right slot.
    send_slot(1'b0, 32'hDEAD_BEEF, 12, -1);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    send_slot(1'b0, 32'h0F0F_0F0F, 20, -1);
    send_slot(1'b1, 32'hF0F0_F0F0, 10, -1);
    rst_n = 1'b1;
    send_slot(1'b1, 32'h3333_3333, 22, -1);
    check("post_rst_nopair24", 32'(q24.size()), 32'd0);
    frame(32'h6B6B_6B6B, 32'h9494_9494);
    frame(32'hA5A5_A5A5, 32'h5A5A_5A5A);
    check("final_err24", 32'(errs24), 32'd1);
    check("final_err16", 32'(errs16), 32'd1);

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
